// File: rtl/pattern_tx_pkg.sv
// Shared symbol, state and marker constants for the
// BBCBC pattern transmitter and detector.
package pattern_tx_pkg;

  localparam logic SYM_B = 1'b0;
  localparam logic SYM_C = 1'b1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_WORD = 2'd1;
  localparam logic [1:0] ST_SEND_PAT  = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam int DEF_PAT_LEN = 5;

  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = {
    SYM_B, SYM_B, SYM_C, SYM_B, SYM_C
  };

  function automatic logic [3:0] clamp_len(
    input logic [3:0] len,
    input int         width
  );
    if (int'(len) > width) begin
      return 4'(width);
    end
    return len;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Loadable MSB-first parallel-in/serial-out shifter.
// Zeros shift in behind the data, so bit_out idles low.
module piso_shift #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] len,
  output logic          bit_out,
  output logic [CW-1:0] remaining
);

  logic [W-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      remaining <= '0;
    end else if (load) begin
      sreg      <= data;
      remaining <= len;
    end else if (shift && remaining != '0) begin
      sreg      <= sreg << 1;
      remaining <= remaining - CW'(1);
    end
  end

  assign bit_out = sreg[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial word/marker transmitter feeding the BBCBC
// detector; markers preempt idle words, never words.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int GAP     = 1,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic [3:0]       len_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             pat_req,
  output logic             d_out,
  output logic             valid_out,
  output logic             busy,
  output logic [7:0]       pat_count
);

  localparam int PW = (WIDTH > PAT_LEN) ? WIDTH : PAT_LEN;
  localparam int CW = $clog2(PW + 1);
  localparam int GW = 4;

  localparam logic [PW-1:0] PAT_ALIGNED =
    PW'(PATTERN) << (PW - PAT_LEN);

  localparam logic [1:0] ST_AFTER =
    (GAP > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic          pending;
  logic          pending_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_n;
  logic          valid_n;
  logic          pat_inc;

  logic          load;
  logic          shift;
  logic [PW-1:0] load_data;
  logic [CW-1:0] load_len;
  logic          ser_bit;
  logic [CW-1:0] remaining;

  logic [3:0]    len_c;
  logic [PW-1:0] word_aligned;
  logic          start_pat;
  logic          take_word;
  logic          last_bit;

  assign len_c = clamp_len(len_in, WIDTH);

  assign word_aligned =
    PW'(word_in) << (PW - int'(len_c));

  // A fresh pat_req in IDLE counts as pending this cycle.
  assign start_pat = (state == ST_IDLE)
                   && (pending || pat_req);

  assign word_ready = (state == ST_IDLE)
                    && !pending && !pat_req;

  assign take_word = word_ready && word_valid;
  assign last_bit  = (remaining == CW'(1));

  assign pending_n = start_pat ? 1'b0
                   : (pending || pat_req);

  always_comb begin
    state_n   = state;
    gap_n     = gap_cnt;
    valid_n   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = '0;
    load_len  = '0;
    pat_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_pat) begin
          state_n   = ST_SEND_PAT;
          load      = 1'b1;
          load_data = PAT_ALIGNED;
          load_len  = CW'(PAT_LEN);
          valid_n   = 1'b1;
        end else if (take_word) begin
          if (len_c == 4'd0) begin
            state_n = ST_AFTER;
            gap_n   = GW'(GAP);
          end else begin
            state_n   = ST_SEND_WORD;
            load      = 1'b1;
            load_data = word_aligned;
            load_len  = CW'(len_c);
            valid_n   = 1'b1;
          end
        end
      end
      ST_SEND_WORD, ST_SEND_PAT: begin
        shift = 1'b1;
        if (last_bit) begin
          state_n = ST_AFTER;
          gap_n   = GW'(GAP);
          pat_inc = (state == ST_SEND_PAT);
        end else begin
          valid_n = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GW'(1)) begin
          state_n = ST_IDLE;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gap_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      gap_cnt   <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      pat_count <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      gap_cnt   <= gap_n;
      valid_out <= valid_n;
      busy      <= (state_n != ST_IDLE);
      if (pat_inc) begin
        pat_count <= pat_count + 8'd1;
      end
    end
  end

  piso_shift #(
    .W  (PW),
    .CW (CW)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .data      (load_data),
    .len       (load_len),
    .bit_out   (ser_bit),
    .remaining (remaining)
  );

  // The shifter empties to zero, so this flop idles low.
  assign d_out = ser_bit;

endmodule
